nway_cache_array: RTL



---
 rtl/cache_pkg.sv | 26 ++
 rtl/plru_tree.sv | 50 +++++
 rtl/nway_cache_array.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared types and width helpers for the set-associative cache array.
package cache_pkg;

    // Widest tag any instance may use; each instance keeps its tag in the low bits.
    localparam int MAX_TAG_WIDTH = 64;

    typedef enum logic [2:0] {
        IDLE,
        EVICT,
        REFILL,
        RESP,
        FLUSH
    } state_t;

    typedef struct packed {
        logic                     valid;
        logic                     dirty;
        logic [MAX_TAG_WIDTH-1:0] tag;
    } line_meta_t;

    // A select field is never narrower than one bit, even for a single entry.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/plru_tree.sv
// Tree pseudo-LRU: victim lookup and post-access node update for one set.
module plru_tree
    import cache_pkg::*;
#(
    parameter int  NUM_WAYS   = 4,
    localparam int WAY_WIDTH  = width_of(NUM_WAYS),
    localparam int BITS       = (NUM_WAYS > 1) ? NUM_WAYS - 1 : 1
)(
    input  logic [BITS-1:0]      bits,
    input  logic [WAY_WIDTH-1:0] access_way,
    output logic [WAY_WIDTH-1:0] victim,
    output logic [BITS-1:0]      next_bits
);

    localparam int LEVELS = $clog2(NUM_WAYS);

    generate
        if (NUM_WAYS == 1) begin : g_single
            assign victim    = '0;
            assign next_bits = '0;
        end else begin : g_tree
            // Nodes are heap-ordered: root 0, children of n at 2n+1 (lower) and 2n+2 (upper).
            always_comb begin
                logic [WAY_WIDTH-1:0] node;
                victim = '0;
                node   = '0;
                for (int l = 0; l < LEVELS; l++) begin
                    victim = WAY_WIDTH'({victim, bits[node]});
                    node   = WAY_WIDTH'(2 * int'(node) + 1 + int'(bits[node]));
                end
            end

            always_comb begin
                logic [WAY_WIDTH-1:0] node;
                logic [WAY_WIDTH-1:0] way;
                logic                 dir;
                next_bits = bits;
                node      = '0;
                way       = access_way;
                for (int l = 0; l < LEVELS; l++) begin
                    dir             = way[WAY_WIDTH-1];
                    next_bits[node] = ~dir;
                    node            = WAY_WIDTH'(2 * int'(node) + 1 + int'(dir));
                    way             = way << 1;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/nway_cache_array.sv
// N-way set-associative write-back cache array with tree PLRU, evict/refill handshakes and flush.
module nway_cache_array
    import cache_pkg::*;
#(
    parameter int  WORD_SIZE       = 32,
    parameter int  WORDS_PER_BLOCK = 4,
    parameter int  NUM_WAYS        = 4,
    parameter int  NUM_SETS        = 16,
    parameter int  TAG_WIDTH       = 25,
    localparam int INDEX_WIDTH     = width_of(NUM_SETS),
    localparam int OFFSET_WIDTH    = width_of(WORDS_PER_BLOCK),
    localparam int BE_WIDTH        = WORD_SIZE / 8,
    localparam int LINE_WIDTH      = WORDS_PER_BLOCK * WORD_SIZE
)(
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic                             req_we,
    input  logic [TAG_WIDTH-1:0]             req_tag,
    input  logic [INDEX_WIDTH-1:0]           req_index,
    input  logic [OFFSET_WIDTH-1:0]          req_offset,
    input  logic [WORD_SIZE-1:0]             req_wdata,
    input  logic [BE_WIDTH-1:0]              req_be,
    output logic                             rsp_valid,
    output logic                             rsp_hit,
    output logic [WORD_SIZE-1:0]             rsp_rdata,
    output logic                             evict_valid,
    input  logic                             evict_ready,
    output logic [TAG_WIDTH+INDEX_WIDTH-1:0] evict_addr,
    output logic [LINE_WIDTH-1:0]            evict_data,
    output logic                             refill_ready,
    input  logic                             refill_valid,
    input  logic [LINE_WIDTH-1:0]            refill_data,
    input  logic                             flush_req,
    output logic                             flush_done
);

    localparam int WAY_WIDTH  = width_of(NUM_WAYS);
    localparam int BYTE_WIDTH = width_of(BE_WIDTH);
    localparam int PLRU_WIDTH = (NUM_WAYS > 1) ? NUM_WAYS - 1 : 1;

    typedef logic [BE_WIDTH-1:0][7:0]                      word_t;
    typedef logic [WORDS_PER_BLOCK-1:0][BE_WIDTH-1:0][7:0] line_t;

    line_meta_t            meta     [NUM_SETS][NUM_WAYS];
    line_t                 data_mem [NUM_SETS][NUM_WAYS];
    logic [PLRU_WIDTH-1:0] plru_mem [NUM_SETS];

    state_t state, state_next;

    logic                    cur_we;
    logic [TAG_WIDTH-1:0]    cur_tag;
    logic [INDEX_WIDTH-1:0]  cur_index;
    logic [OFFSET_WIDTH-1:0] cur_offset;
    word_t                   cur_wdata;
    logic [BE_WIDTH-1:0]     cur_be;
    logic [WAY_WIDTH-1:0]    cur_victim;

    logic [INDEX_WIDTH-1:0]  flush_set;
    logic [WAY_WIDTH-1:0]    flush_way;
    logic                    flush_dirty, flush_last, flush_advance;

    logic                    accept, hit, free_found, victim_dirty;
    logic [WAY_WIDTH-1:0]    hit_way, free_way, victim_way;
    line_t                   hit_line, hit_merged, fill_line;

    logic [INDEX_WIDTH-1:0]  plru_index;
    logic [WAY_WIDTH-1:0]    plru_access, plru_victim;
    logic [PLRU_WIDTH-1:0]   plru_next;

    function automatic line_t merge_write(input line_t line, input logic [OFFSET_WIDTH-1:0] off,
                                          input word_t wdata, input logic [BE_WIDTH-1:0] be);
        line_t res;
        res = line;
        for (int b = 0; b < BE_WIDTH; b++) begin
            if (be[BYTE_WIDTH'(b)])
                res[off][BYTE_WIDTH'(b)] = wdata[BYTE_WIDTH'(b)];
        end
        return res;
    endfunction

    // Tag match and victim choice look straight at the incoming request while idle.
    always_comb begin
        hit        = 1'b0;
        hit_way    = '0;
        free_found = 1'b0;
        free_way   = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (meta[req_index][WAY_WIDTH'(w)].valid &&
                meta[req_index][WAY_WIDTH'(w)].tag == MAX_TAG_WIDTH'(req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_WIDTH'(w);
            end
            if (!meta[req_index][WAY_WIDTH'(w)].valid && !free_found) begin
                free_found = 1'b1;
                free_way   = WAY_WIDTH'(w);
            end
        end
        victim_way   = free_found ? free_way : plru_victim;
        victim_dirty = meta[req_index][victim_way].valid && meta[req_index][victim_way].dirty;
    end

    always_comb begin
        hit_line   = data_mem[req_index][hit_way];
        hit_merged = merge_write(hit_line, req_offset, req_wdata, req_be);
        fill_line  = cur_we ? merge_write(refill_data, cur_offset, cur_wdata, cur_be) : line_t'(refill_data);
    end

    // One PLRU unit serves both the idle lookup and the install on refill.
    always_comb begin
        plru_index  = (state == REFILL) ? cur_index  : req_index;
        plru_access = (state == REFILL) ? cur_victim : hit_way;
    end

    plru_tree #(.NUM_WAYS(NUM_WAYS)) u_plru (
        .bits       (plru_mem[plru_index]),
        .access_way (plru_access),
        .victim     (plru_victim),
        .next_bits  (plru_next)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next    = state;
        req_ready     = 1'b0;
        accept        = 1'b0;
        evict_valid   = 1'b0;
        refill_ready  = 1'b0;
        flush_dirty   = meta[flush_set][flush_way].valid && meta[flush_set][flush_way].dirty;
        flush_last    = (flush_set == INDEX_WIDTH'(NUM_SETS - 1)) && (flush_way == WAY_WIDTH'(NUM_WAYS - 1));
        flush_advance = 1'b0;
        evict_addr    = {meta[cur_index][cur_victim].tag[TAG_WIDTH-1:0], cur_index};
        evict_data    = data_mem[cur_index][cur_victim];
        case (state)
            IDLE: begin
                if (flush_req) begin
                    state_next = FLUSH;
                end else begin
                    req_ready = 1'b1;
                    if (req_valid) begin
                        accept = 1'b1;
                        if (!hit)
                            state_next = victim_dirty ? EVICT : REFILL;
                    end
                end
            end
            EVICT: begin
                evict_valid = 1'b1;
                if (evict_ready)
                    state_next = REFILL;
            end
            REFILL: begin
                refill_ready = 1'b1;
                if (refill_valid)
                    state_next = RESP;
            end
            RESP: state_next = IDLE;
            FLUSH: begin
                evict_addr    = {meta[flush_set][flush_way].tag[TAG_WIDTH-1:0], flush_set};
                evict_data    = data_mem[flush_set][flush_way];
                evict_valid   = flush_dirty;
                flush_advance = !flush_dirty || evict_ready;
                if (flush_advance && flush_last)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        rsp_valid  <= 1'b0;
        rsp_hit    <= 1'b0;
        flush_done <= 1'b0;
        if (rst) begin
            rsp_rdata <= '0;
            flush_set <= '0;
            flush_way <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                plru_mem[INDEX_WIDTH'(s)] <= '0;
                for (int w = 0; w < NUM_WAYS; w++)
                    meta[INDEX_WIDTH'(s)][WAY_WIDTH'(w)] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cur_we     <= req_we;
                        cur_tag    <= req_tag;
                        cur_index  <= req_index;
                        cur_offset <= req_offset;
                        cur_wdata  <= req_wdata;
                        cur_be     <= req_be;
                        cur_victim <= victim_way;
                        if (hit) begin
                            plru_mem[req_index] <= plru_next;
                            rsp_valid           <= 1'b1;
                            rsp_hit             <= 1'b1;
                            rsp_rdata           <= req_we ? hit_merged[req_offset] : hit_line[req_offset];
                            if (req_we)
                                meta[req_index][hit_way].dirty <= 1'b1;
                        end
                    end
                end
                REFILL: begin
                    if (refill_valid) begin
                        meta[cur_index][cur_victim] <= '{valid: 1'b1, dirty: cur_we, tag: MAX_TAG_WIDTH'(cur_tag)};
                        plru_mem[cur_index]         <= plru_next;
                        rsp_valid                   <= 1'b1;
                        rsp_rdata                   <= fill_line[cur_offset];
                    end
                end
                // Sweep set-major, way-minor; each line is dropped once any write-back completes.
                FLUSH: begin
                    if (flush_advance) begin
                        meta[flush_set][flush_way] <= '0;
                        plru_mem[flush_set]        <= '0;
                        if (flush_way == WAY_WIDTH'(NUM_WAYS - 1)) begin
                            flush_way <= '0;
                            flush_set <= (flush_set == INDEX_WIDTH'(NUM_SETS - 1)) ? '0 : flush_set + 1'b1;
                        end else begin
                            flush_way <= flush_way + 1'b1;
                        end
                        if (flush_last)
                            flush_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (accept && hit && req_we)
                data_mem[req_index][hit_way] <= hit_merged;
            else if (state == REFILL && refill_valid)
                data_mem[cur_index][cur_victim] <= fill_line;
        end
    end

endmodule
